// File: rtl/ins_line_fill.sv
// Instruction line fill engine: streams one line from local store as quadword
// reads and assembles it into the word array consumed by instruction fetch.
module ins_line_fill #(
  parameter int LINE_WORDS = 256,
  parameter int LS_AW      = 18,
  parameter int MAX_OUT    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fill_req,
  input  logic [LS_AW-1:0]             fill_base,
  output logic                         ls_req,
  output logic [LS_AW-1:0]             ls_addr,
  input  logic                         ls_gnt,
  input  logic                         ls_rvalid,
  input  logic [127:0]                 ls_rdata,
  output logic [LINE_WORDS-1:0][31:0]  ins_cache,
  output logic                         line_valid,
  output logic                         busy,
  output logic                         fill_done,
  output logic                         err
);

  localparam int QW = LINE_WORDS / 4;
  localparam int CW = $clog2(QW + 1);
  localparam int OW = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t           state_reg, state_next;
  logic [LS_AW-1:0] base_reg, pend_base_reg, base_aligned;
  logic             pending_reg, req_prev_reg, line_valid_reg, err_reg;
  logic [CW-1:0]    iss_cnt_reg, ret_cnt_reg;
  logic [OW-1:0]    inflight_reg;
  logic             issue, ret, stray, req_rise;
  logic             start_idle, restart, to_done;

  assign base_aligned = fill_base & ~LS_AW'(15);
  assign ls_addr      = base_reg + LS_AW'({iss_cnt_reg, 4'b0000});
  assign issue        = ls_req && ls_gnt;
  // A response with nothing outstanding cannot belong to this fill.
  assign ret          = ls_rvalid && (inflight_reg != '0);
  assign stray        = ls_rvalid && (inflight_reg == '0);
  assign req_rise     = fill_req && !req_prev_reg;
  assign line_valid   = line_valid_reg;
  assign err          = err_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    ls_req     = 1'b0;
    busy       = 1'b0;
    fill_done  = 1'b0;
    start_idle = 1'b0;
    restart    = 1'b0;
    to_done    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fill_req) begin
          start_idle = 1'b1;
          state_next = FILL;
        end
      end
      FILL: begin
        busy   = 1'b1;
        ls_req = (iss_cnt_reg < CW'(QW)) && (inflight_reg < OW'(MAX_OUT));
        if (ret && (ret_cnt_reg == CW'(QW - 1))) begin
          to_done    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        fill_done = 1'b1;
        if (pending_reg) begin
          restart    = 1'b1;
          state_next = FILL;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_reg       <= '0;
      pend_base_reg  <= '0;
      pending_reg    <= 1'b0;
      req_prev_reg   <= 1'b0;
      line_valid_reg <= 1'b0;
      err_reg        <= 1'b0;
      iss_cnt_reg    <= '0;
      ret_cnt_reg    <= '0;
      inflight_reg   <= '0;
    end else begin
      req_prev_reg <= fill_req;
      if (stray) err_reg <= 1'b1;

      if (start_idle) begin
        base_reg       <= base_aligned;
        line_valid_reg <= 1'b0;
      end else if (restart) begin
        base_reg       <= pend_base_reg;
        pending_reg    <= 1'b0;
        line_valid_reg <= 1'b0;
      end else if (to_done) begin
        line_valid_reg <= 1'b1;
      end

      // Only the newest request made during a fill is remembered.
      if (state_reg == FILL && req_rise) begin
        pending_reg   <= 1'b1;
        pend_base_reg <= base_aligned;
      end

      if (start_idle || restart) begin
        iss_cnt_reg <= '0;
        ret_cnt_reg <= '0;
      end else begin
        if (issue) iss_cnt_reg <= iss_cnt_reg + CW'(1);
        if (ret)   ret_cnt_reg <= ret_cnt_reg + CW'(1);
      end

      case ({issue, ret})
        2'b10:   inflight_reg <= inflight_reg + OW'(1);
        2'b01:   inflight_reg <= inflight_reg - OW'(1);
        default: inflight_reg <= inflight_reg;
      endcase
    end
  end

  for (genvar gi = 0; gi < QW; gi++) begin : g_qw
    logic [127:0] q_reg;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                q_reg <= '0;
      else if (ret && (ret_cnt_reg == CW'(gi)))  q_reg <= ls_rdata;
    end
    assign ins_cache[4*gi +: 4] = q_reg;
  end

endmodule

// File: tb/tb_ins_line_fill.sv
// Directed bench for ins_line_fill with a fixed-latency in-order local store
// responder and an address/data scoreboard.
module tb_ins_line_fill;
  localparam int LW = 256;
  localparam int QW = LW / 4;
  localparam int AW = 18;

  logic                clk = 1'b0;
  logic                reset;
  logic                fill_req;
  logic [AW-1:0]       fill_base;
  logic                ls_req;
  logic [AW-1:0]       ls_addr;
  logic                ls_gnt;
  logic                ls_rvalid;
  logic [127:0]        ls_rdata;
  logic [LW-1:0][31:0] ins_cache;
  logic                line_valid, busy, fill_done, err;

  ins_line_fill #(.LINE_WORDS(LW), .LS_AW(AW), .MAX_OUT(4)) dut (
    .clk(clk), .reset(reset), .fill_req(fill_req), .fill_base(fill_base),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata), .ins_cache(ins_cache), .line_valid(line_valid),
    .busy(busy), .fill_done(fill_done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 2;
  bit gnt_toggle = 1'b0;
  bit lv_watch   = 1'b0;
  int n_iss, n_ret, n_done, outstanding, max_seen;
  logic [AW-1:0] exp_addr[$];
  logic [AW-1:0] rq_addr[$];
  int            rq_due[$];

  task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [127:0] qdata(logic [AW-1:0] a);
    logic [31:0] w;
    w = 32'(a >> 2);
    return {w + 32'd3, w + 32'd2, w + 32'd1, w};
  endfunction

  task automatic push_exp(logic [AW-1:0] base);
    logic [AW-1:0] b;
    b = base & ~AW'(15);
    for (int i = 0; i < QW; i++) exp_addr.push_back(b + AW'(16 * i));
  endtask

  task automatic clear_stats();
    n_iss = 0; n_ret = 0; n_done = 0; outstanding = 0; max_seen = 0;
  endtask

  // One clock: account for what the DUT did at this edge, then drive the next inputs.
  task automatic step();
    bit iss, rv, stall;
    logic [AW-1:0] a;
    iss   = ls_req && ls_gnt;
    rv    = ls_rvalid;
    stall = ls_req && !ls_gnt;
    a     = ls_addr;
    @(posedge clk); #1;
    cyc++;
    if (iss) begin
      n_iss++;
      outstanding++;
      if (exp_addr.size() == 0) check("unexpected_issue", 64'(a), 64'h3FFFFFFFF);
      else check("ls_addr", 64'(a), 64'(exp_addr.pop_front()));
      rq_addr.push_back(a);
      rq_due.push_back(cyc + lat);
    end
    if (rv) begin
      n_ret++;
      outstanding--;
    end
    if (outstanding > max_seen) max_seen = outstanding;
    if (stall) begin
      check("hold_req", 64'(ls_req), 64'd1);
      check("hold_addr", 64'(ls_addr), 64'(a));
    end
    if (fill_done) n_done++;
    if (lv_watch && busy) check("line_valid_low_in_fill", 64'(line_valid), 64'd0);
    ls_gnt = gnt_toggle ? ~ls_gnt : 1'b1;
    if (rq_due.size() > 0 && rq_due[0] <= cyc + 1) begin
      ls_rvalid = 1'b1;
      ls_rdata  = qdata(rq_addr.pop_front());
      void'(rq_due.pop_front());
    end else begin
      ls_rvalid = 1'b0;
      ls_rdata  = '0;
    end
  endtask

  task automatic wait_done(string tag, int budget, output int cycles);
    cycles = 0;
    while (!fill_done && cycles < budget) begin
      step();
      cycles++;
    end
    check({tag, "_done_seen"}, 64'(fill_done), 64'd1);
  endtask

  task automatic check_line(string tag, logic [AW-1:0] base);
    logic [AW-1:0] b, t;
    logic [31:0]   expv;
    int            idx;
    b = base & ~AW'(15);
    idx = LW - 1;
    for (int i = LW - 1; i >= 0; i--) begin
      t = b + AW'(4 * i);
      if (ins_cache[i] !== 32'(t >> 2)) idx = i;
    end
    t = b + AW'(4 * idx);
    expv = 32'(t >> 2);
    check(tag, 64'(ins_cache[idx]), 64'(expv));
  endtask

  task automatic start_fill(logic [AW-1:0] base, bit hold);
    fill_base = base;
    fill_req  = 1'b1;
    push_exp(base);
    step();
    if (!hold) fill_req = 1'b0;
  endtask

  initial begin
    int cyc_n;
    int guard;
    reset = 1'b0; fill_req = 1'b0; fill_base = '0;
    ls_gnt = 1'b1; ls_rvalid = 1'b0; ls_rdata = '0;
    clear_stats();
    #12;
    check("rst_ls_req", 64'(ls_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_line_valid", 64'(line_valid), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_cache", 64'(|ins_cache), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Basic fill, L=2
    lat = 2; gnt_toggle = 1'b0; clear_stats();
    start_fill(18'h00100, 1'b0);
    check("basic_first_addr", 64'(ls_addr), 64'h00100);
    check("basic_busy", 64'(busy), 64'd1);
    wait_done("basic", 400, cyc_n);
    check("basic_lv", 64'(line_valid), 64'd1);
    check("basic_w0", 64'(ins_cache[0]), 64'h40);
    check("basic_w255", 64'(ins_cache[255]), 64'h13F);
    check_line("basic_line", 18'h00100);
    step();
    check("basic_done_once", 64'(n_done), 64'd1);
    check("basic_idle", 64'(busy), 64'd0);
    check("basic_lv_hold", 64'(line_valid), 64'd1);
    check("basic_err", 64'(err), 64'd0);

    // Backpressure: gnt toggles, L=6
    lat = 6; gnt_toggle = 1'b1; clear_stats();
    start_fill(18'h08000, 1'b0);
    wait_done("bp", 1000, cyc_n);
    check("bp_max_inflight_le4", 64'(max_seen <= 4), 64'd1);
    check("bp_issues", 64'(n_iss), 64'd64);
    check("bp_returns", 64'(n_ret), 64'd64);
    check_line("bp_line", 18'h08000);
    gnt_toggle = 1'b0;
    step();

    // Wrap-around, L=8 so MAX_OUT caps issue; fill_req held high throughout
    lat = 8; clear_stats();
    start_fill(18'h3FE0F, 1'b1);
    check("wrap_first_addr", 64'(ls_addr), 64'h3FE00);
    wait_done("wrap", 1000, cyc_n);
    check("wrap_max_inflight", 64'(max_seen), 64'd4);
    check("wrap_w127", 64'(ins_cache[127]), 64'hFFFF);
    check("wrap_w128", 64'(ins_cache[128]), 64'h0);
    check_line("wrap_line", 18'h3FE0F);
    fill_req = 1'b0;
    step();
    check("wrap_no_retrigger", 64'(busy), 64'd0);
    step();
    check("wrap_no_retrigger2", 64'(busy), 64'd0);

    // Pending request: two rising edges during a fill, only the latest survives
    lat = 2; clear_stats();
    start_fill(18'h00100, 1'b0);
    guard = 0;
    while (n_ret < 10 && guard < 200) begin step(); guard++; end
    check("pend_reach_q10", 64'(n_ret >= 10), 64'd1);
    fill_base = 18'h02000; fill_req = 1'b1;
    step();
    fill_req = 1'b0;
    step(); step();
    fill_base = 18'h03000; fill_req = 1'b1;
    push_exp(18'h03000);
    step();
    fill_req = 1'b0;
    wait_done("pend1", 400, cyc_n);
    check_line("pend1_line", 18'h00100);
    lv_watch = 1'b1;
    step();
    check("pend2_busy", 64'(busy), 64'd1);
    check("pend2_addr", 64'(ls_addr), 64'h03000);
    wait_done("pend2", 400, cyc_n);
    lv_watch = 1'b0;
    check_line("pend2_line", 18'h03000);
    for (int i = 0; i < 4; i++) step();
    check("pend_no_third", 64'(busy), 64'd0);
    check("pend_exp_empty", 64'(exp_addr.size()), 64'd0);
    check("pend_done_count", 64'(n_done), 64'd2);

    // Reset mid-fill at ret_cnt=20
    lat = 3; clear_stats();
    start_fill(18'h00500, 1'b0);
    guard = 0;
    while (n_ret < 20 && guard < 200) begin step(); guard++; end
    reset = 1'b0;
    #1;
    check("mid_rst_ls_req", 64'(ls_req), 64'd0);
    check("mid_rst_addr", 64'(ls_addr), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(fill_done), 64'd0);
    check("mid_rst_lv", 64'(line_valid), 64'd0);
    check("mid_rst_err", 64'(err), 64'd0);
    check("mid_rst_cache", 64'(|ins_cache), 64'd0);
    rq_addr.delete(); rq_due.delete(); exp_addr.delete();
    ls_rvalid = 1'b0; ls_rdata = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    ls_rvalid = 1'b1; ls_rdata = {4{32'hDEADBEEF}};
    @(posedge clk); #1;
    ls_rvalid = 1'b0; ls_rdata = '0;
    check("stray_err", 64'(err), 64'd1);
    check("stray_no_write", 64'(|ins_cache), 64'd0);
    check("stray_idle", 64'(busy), 64'd0);

    // Simultaneous issue/return with L=1
    lat = 1; clear_stats();
    start_fill(18'h00800, 1'b0);
    check("sim_req_next_cycle", 64'(ls_req), 64'd1);
    wait_done("sim", 200, cyc_n);
    check("sim_latency", 64'(cyc_n + 1), 64'd66);
    check("sim_inflight_const", 64'(max_seen), 64'd1);
    check_line("sim_line", 18'h00800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
